// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with WB_PORTS writeback channels, occupancy tracking and optional dual in-order commit.
// Optional feature macro: ROB_DUAL_COMMIT_EN enables commit slot 1 (real_commit can reach 2).
// Ports: clk_in/rst_in/rdy_in control; inst_* / ins_* dispatch; wb_* packed writeback; rs1_*/rs2_* operand lookup;
//        rob_tail/rob_full/rob_empty/new_* dispatch status; commit0_*/commit1_* register writes;
//        rob_head/rob_head_l_or_s head status; clear_flag/pc_fact flush; real_commit/commit_count statistics.
`ifndef ROB_TYPE
`define ROB_TYPE 1:0
`endif
`ifndef TypeRd
`define TypeRd 2'd0
`endif
`ifndef TypeLd
`define TypeLd 2'd1
`endif
`ifndef TypeSt
`define TypeSt 2'd2
`endif
`ifndef TypeBr
`define TypeBr 2'd3
`endif
module rob_multi_commit #(
  parameter int ROB_DEPTH_BIT = 5,
  parameter int WB_PORTS = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              inst_valid,
  input  logic                              inst_ready,
  input  logic [31:0]                       ins_value,
  input  logic [4:0]                        ins_rd,
  input  logic [`ROB_TYPE]                  ins_type,
  input  logic [31:0]                       ins_addr,
  input  logic [31:0]                       ins_jpaddr,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS*ROB_DEPTH_BIT-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]            wb_val,
  input  logic [ROB_DEPTH_BIT-1:0]          rs1_id,
  input  logic [ROB_DEPTH_BIT-1:0]          rs2_id,
  output logic                              rs1_ready,
  output logic                              rs2_ready,
  output logic [31:0]                       rs1_val,
  output logic [31:0]                       rs2_val,
  output logic [ROB_DEPTH_BIT-1:0]          rob_tail,
  output logic                              rob_full,
  output logic                              rob_empty,
  output logic [4:0]                        new_reg_id,
  output logic [ROB_DEPTH_BIT-1:0]          new_rob_id,
  output logic                              commit0_valid,
  output logic                              commit1_valid,
  output logic [4:0]                        commit0_rd,
  output logic [4:0]                        commit1_rd,
  output logic [31:0]                       commit0_val,
  output logic [31:0]                       commit1_val,
  output logic [ROB_DEPTH_BIT-1:0]          commit0_id,
  output logic [ROB_DEPTH_BIT-1:0]          commit1_id,
  output logic                              rob_head_l_or_s,
  output logic [ROB_DEPTH_BIT-1:0]          rob_head,
  output logic                              clear_flag,
  output logic [31:0]                       pc_fact,
  output logic [1:0]                        real_commit,
  output logic [31:0]                       commit_count
);
  localparam int B = ROB_DEPTH_BIT;
  localparam int DEPTH = 1 << B;
  logic [DEPTH-1:0] busy_q, busy_d, rdy_q, rdy_d, jp_q, jp_d;
  logic [31:0] val_q [DEPTH];
  logic [31:0] val_d [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [4:0] rd_d [DEPTH];
  logic [1:0] typ_q [DEPTH];
  logic [1:0] typ_d [DEPTH];
  logic [B-1:0] head_q, head_d, tail_q, tail_d, head1;
  logic [B:0] cnt_q, cnt_d;
  logic clear_q, clear_d;
  logic [31:0] pc_q, pc_d, cc_q;
  logic [1:0] rc_q, n_fire;
  logic acc, fire0, fire1, mis0;
  logic [B-1:0] rs_id [2];
  logic [1:0] rs_rdy;
  logic [31:0] rs_val [2];
  logic unused_inputs;
  // Only bit 0 of the predicted target takes part in the mispredict test, so the PC and upper target bits are not kept.
  assign unused_inputs = ^{ins_addr, ins_jpaddr[31:1]};
  assign head1 = head_q + 1'b1;
  assign acc = rdy_in && !clear_q && inst_valid && !cnt_q[B];
  assign fire0 = busy_q[head_q] && rdy_q[head_q] && rdy_in && !clear_q;
  assign mis0 = fire0 && typ_q[head_q] == `TypeBr && (val_q[head_q][0] ^ jp_q[head_q]);
`ifdef ROB_DUAL_COMMIT_EN
  assign fire1 = fire0 && !mis0 && busy_q[head1] && rdy_q[head1] && typ_q[head1] == `TypeRd;
`else
  assign fire1 = 1'b0;
`endif
  assign n_fire = {1'b0, fire0} + {1'b0, fire1};
  always_comb begin
    busy_d = busy_q;
    rdy_d = rdy_q;
    jp_d = jp_q;
    val_d = val_q;
    rd_d = rd_q;
    typ_d = typ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d = cnt_q;
    clear_d = clear_q;
    pc_d = pc_q;
    if (clear_q && rdy_in) begin
      busy_d = '0;
      rdy_d = '0;
      jp_d = '0;
      val_d = '{default: '0};
      rd_d = '{default: '0};
      typ_d = '{default: '0};
      head_d = '0;
      tail_d = '0;
      cnt_d = '0;
      clear_d = 1'b0;
      pc_d = '0;
    end else if (rdy_in) begin
      if (acc) begin
        busy_d[tail_q] = 1'b1;
        rdy_d[tail_q] = inst_ready;
        val_d[tail_q] = ins_value;
        rd_d[tail_q] = ins_rd;
        typ_d[tail_q] = ins_type;
        jp_d[tail_q] = ins_jpaddr[0];
        tail_d = tail_q + 1'b1;
      end
      // Applied after dispatch so a writeback to the tail entry wins; ascending order lets the higher channel win.
      for (int k = 0; k < WB_PORTS; k++)
        if (wb_valid[k]) begin
          rdy_d[wb_id[k*B +: B]] = 1'b1;
          val_d[wb_id[k*B +: B]] = wb_val[k*32 +: 32];
        end
      if (fire0) begin
        busy_d[head_q] = 1'b0;
        rdy_d[head_q] = 1'b0;
      end
      if (fire1) begin
        busy_d[head1] = 1'b0;
        rdy_d[head1] = 1'b0;
      end
      head_d = head_q + B'(n_fire);
      cnt_d = cnt_q + (B+1)'(acc) - (B+1)'(n_fire);
      if (mis0) begin
        clear_d = 1'b1;
        pc_d = val_q[head_q];
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      rdy_q <= '0;
      jp_q <= '0;
      val_q <= '{default: '0};
      rd_q <= '{default: '0};
      typ_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      clear_q <= 1'b0;
      pc_q <= '0;
      rc_q <= '0;
      cc_q <= '0;
    end else begin
      busy_q <= busy_d;
      rdy_q <= rdy_d;
      jp_q <= jp_d;
      val_q <= val_d;
      rd_q <= rd_d;
      typ_q <= typ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      clear_q <= clear_d;
      pc_q <= pc_d;
      rc_q <= n_fire;
      cc_q <= cc_q + 32'(n_fire);
    end
  end
  assign rs_id[0] = rs1_id;
  assign rs_id[1] = rs2_id;
  // Lookup priority: stored ready value, then lowest writeback channel, then same-cycle ready dispatch.
  always_comb begin
    rs_rdy = '0;
    rs_val = '{default: '0};
    for (int j = 0; j < 2; j++) begin
      if (busy_q[rs_id[j]] && rdy_q[rs_id[j]]) begin
        rs_rdy[j] = 1'b1;
        rs_val[j] = val_q[rs_id[j]];
      end else begin
        for (int k = WB_PORTS - 1; k >= 0; k--)
          if (wb_valid[k] && wb_id[k*B +: B] == rs_id[j]) begin
            rs_rdy[j] = 1'b1;
            rs_val[j] = wb_val[k*32 +: 32];
          end
        if (!rs_rdy[j] && acc && inst_ready && tail_q == rs_id[j]) begin
          rs_rdy[j] = 1'b1;
          rs_val[j] = ins_value;
        end
      end
    end
  end
  assign rs1_ready = rs_rdy[0];
  assign rs2_ready = rs_rdy[1];
  assign rs1_val = rs_val[0];
  assign rs2_val = rs_val[1];
  assign rob_tail = tail_q;
  assign rob_head = head_q;
  assign rob_empty = cnt_q == '0;
  assign rob_full = cnt_q[B] || (inst_valid && &cnt_q[B-1:0]);
  assign new_reg_id = (acc && (ins_type == `TypeRd || ins_type == `TypeLd)) ? ins_rd : 5'd0;
  assign new_rob_id = (acc && (ins_type == `TypeRd || ins_type == `TypeLd)) ? tail_q : '0;
  assign commit0_valid = fire0 && (typ_q[head_q] == `TypeRd || typ_q[head_q] == `TypeLd);
  assign commit1_valid = fire1;
  assign commit0_rd = commit0_valid ? rd_q[head_q] : 5'd0;
  assign commit1_rd = commit1_valid ? rd_q[head1] : 5'd0;
  assign commit0_val = commit0_valid ? val_q[head_q] : 32'd0;
  assign commit1_val = commit1_valid ? val_q[head1] : 32'd0;
  assign commit0_id = head_q;
  assign commit1_id = head1;
  assign rob_head_l_or_s = busy_q[head_q] && (typ_q[head_q] == `TypeLd || typ_q[head_q] == `TypeSt);
  assign clear_flag = clear_q;
  assign pc_fact = pc_q;
  assign real_commit = rc_q;
  assign commit_count = cc_q;
endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: scoreboard bench for rob_multi_commit (commits checked in order against dispatched/written-back values).
`ifndef ROB_TYPE
`define ROB_TYPE 1:0
`endif
`ifndef TypeRd
`define TypeRd 2'd0
`endif
`ifndef TypeLd
`define TypeLd 2'd1
`endif
`ifndef TypeSt
`define TypeSt 2'd2
`endif
`ifndef TypeBr
`define TypeBr 2'd3
`endif
module tb_rob_multi_commit;
  logic clk_in = 1'b0, rst_in, rdy_in, inst_valid, inst_ready;
  logic [31:0] ins_value, ins_addr, ins_jpaddr;
  logic [4:0] ins_rd;
  logic [1:0] ins_type;
  logic [1:0] wb_valid;
  logic [9:0] wb_id;
  logic [63:0] wb_val;
  logic [4:0] rs1_id, rs2_id;
  logic rs1_ready, rs2_ready, rob_full, rob_empty, commit0_valid, commit1_valid, rob_head_l_or_s, clear_flag;
  logic [31:0] rs1_val, rs2_val, commit0_val, commit1_val, pc_fact, commit_count;
  logic [4:0] rob_tail, new_reg_id, new_rob_id, commit0_rd, commit1_rd, commit0_id, commit1_id, rob_head;
  logic [1:0] real_commit;
  typedef struct {logic [4:0] id; logic [4:0] rd; logic [31:0] val;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  logic [4:0] mtail = '0;
  logic [1:0] rc_max = '0;
  rob_multi_commit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .ins_value(ins_value), .ins_rd(ins_rd), .ins_type(ins_type), .ins_addr(ins_addr), .ins_jpaddr(ins_jpaddr),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rob_tail(rob_tail), .rob_full(rob_full), .rob_empty(rob_empty), .new_reg_id(new_reg_id), .new_rob_id(new_rob_id),
    .commit0_valid(commit0_valid), .commit1_valid(commit1_valid), .commit0_rd(commit0_rd), .commit1_rd(commit1_rd),
    .commit0_val(commit0_val), .commit1_val(commit1_val), .commit0_id(commit0_id), .commit1_id(commit1_id),
    .rob_head_l_or_s(rob_head_l_or_s), .rob_head(rob_head), .clear_flag(clear_flag), .pc_fact(pc_fact),
    .real_commit(real_commit), .commit_count(commit_count)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic sb_pop(input string s, input logic [4:0] id, input logic [4:0] rd, input logic [31:0] v);
    exp_t e;
    if (q.size() == 0) begin
      check({s, "_unexpected"}, 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    check({s, "_id"}, 32'(id), 32'(e.id));
    check({s, "_rd"}, 32'(rd), 32'(e.rd));
    check({s, "_val"}, v, e.val);
  endtask
  always @(negedge clk_in)
    if (!rst_in) begin
      if (real_commit > rc_max) rc_max = real_commit;
      if (commit0_valid) sb_pop("c0", commit0_id, commit0_rd, commit0_val);
      if (commit1_valid) sb_pop("c1", commit1_id, commit1_rd, commit1_val);
    end
  task automatic ng;
    @(negedge clk_in);
  endtask
  task automatic nx;
    @(posedge clk_in);
    #1;
  endtask
  task automatic cyc;
    ng;
    nx;
  endtask
  task automatic idle;
    inst_valid = 1'b0;
    inst_ready = 1'b0;
    wb_valid = '0;
  endtask
  task automatic disp(input logic [4:0] rd, input logic [1:0] t, input logic r, input logic [31:0] v,
                      input logic [31:0] jp, input bit acc, input bit push);
    inst_valid = 1'b1;
    inst_ready = r;
    ins_rd = rd;
    ins_type = t;
    ins_value = v;
    ins_jpaddr = jp;
    ins_addr = 32'h1000 + (32'(mtail) << 2);
    if (acc && push) q.push_back('{id: mtail, rd: rd, val: v});
    if (acc) mtail++;
  endtask
  task automatic wb_set(input int k, input logic [4:0] id, input logic [31:0] v);
    wb_valid[k] = 1'b1;
    wb_id[k*5 +: 5] = id;
    wb_val[k*32 +: 32] = v;
    foreach (q[i]) if (q[i].id == id) q[i].val = v;
  endtask
  task automatic drain;
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc;
    check("drain_left", 32'(q.size()), 32'd0);
  endtask
  task automatic do_reset;
    rst_in = 1'b1;
    idle();
    nx;
    nx;
    q.delete();
    mtail = '0;
    rst_in = 1'b0;
  endtask
  task automatic chk_reset(input string s);
    check({s, "_head"}, 32'(rob_head), 32'd0);
    check({s, "_tail"}, 32'(rob_tail), 32'd0);
    check({s, "_empty"}, 32'(rob_empty), 32'd1);
    check({s, "_full"}, 32'(rob_full), 32'd0);
    check({s, "_clear"}, 32'(clear_flag), 32'd0);
    check({s, "_pc"}, pc_fact, 32'd0);
    check({s, "_rc"}, 32'(real_commit), 32'd0);
    check({s, "_cc"}, commit_count, 32'd0);
  endtask
  initial begin
    rdy_in = 1'b1;
    ins_value = '0; ins_addr = '0; ins_jpaddr = '0; ins_rd = '0; ins_type = '0;
    wb_id = '0; wb_val = '0; rs1_id = '0; rs2_id = '0;
    do_reset;
    ng;
    chk_reset("rst");
    nx;
    disp(5'd1, `TypeRd, 1'b0, 32'd0, 32'd0, 1, 1);
    cyc;
    disp(5'd2, `TypeRd, 1'b1, 32'd6, 32'd0, 1, 1);
    rs1_id = 5'd0;
    ng;
    check("rs_not_ready", 32'(rs1_ready), 32'd0);
    nx;
    disp(5'd3, `TypeRd, 1'b1, 32'd7, 32'd0, 1, 1);
    rs1_id = 5'd1;
    rs2_id = 5'd2;
    ng;
    check("rs_stored_rdy", 32'(rs1_ready), 32'd1);
    check("rs_stored_val", rs1_val, 32'd6);
    check("rs_bypass_rdy", 32'(rs2_ready), 32'd1);
    check("rs_bypass_val", rs2_val, 32'd7);
    nx;
    idle();
    wb_set(0, 5'd0, 32'd5);
    rs2_id = 5'd0;
    ng;
    check("rs_wb_val", rs2_val, 32'd5);
    check("no_commit_before_wb", 32'(commit0_valid), 32'd0);
    nx;
    idle();
    drain;
    ng;
    check("t1_cc", commit_count, 32'd3);
    check("t1_head", 32'(rob_head), 32'd3);
    check("t1_empty", 32'(rob_empty), 32'd1);
`ifdef ROB_DUAL_COMMIT_EN
    check("t1_max_real_commit", 32'(rc_max), 32'd2);
`else
    check("t1_max_real_commit", 32'(rc_max), 32'd1);
`endif
    nx;
    do_reset;
    for (int i = 0; i < 32; i++) begin
      disp(5'(i % 31 + 1), `TypeRd, 1'b0, 32'd0, 32'd0, 1, 1);
      ng;
      if (i == 5) begin
        check("new_rob_id", 32'(new_rob_id), 32'd5);
        check("new_reg_id", 32'(new_reg_id), 32'd6);
      end
      if (i == 30) check("full_at_30", 32'(rob_full), 32'd0);
      if (i == 31) check("full_at_31", 32'(rob_full), 32'd1);
      nx;
    end
    disp(5'd9, `TypeRd, 1'b0, 32'd0, 32'd0, 0, 0);
    ng;
    check("full32", 32'(rob_full), 32'd1);
    check("full32_empty", 32'(rob_empty), 32'd0);
    check("full32_head", 32'(rob_head), 32'd0);
    check("full32_tail", 32'(rob_tail), 32'd0);
    check("ignored_reg_id", 32'(new_reg_id), 32'd0);
    nx;
    idle();
    wb_set(1, 5'd0, 32'h55);
    cyc;
    idle();
    ng;
    check("full_commit", 32'(commit0_valid), 32'd1);
    nx;
    ng;
    check("after_full_head", 32'(rob_head), 32'd1);
    check("after_full_tail", 32'(rob_tail), 32'd0);
    check("after_full_cnt31", 32'(rob_full), 32'd0);
    check("after_full_cc", commit_count, 32'd1);
    nx;
    do_reset;
    disp(5'd0, `TypeBr, 1'b1, 32'h100, 32'h0FD, 1, 0);
    ng;
    check("br_reg_id", 32'(new_reg_id), 32'd0);
    nx;
    disp(5'd3, `TypeRd, 1'b1, 32'h33, 32'd0, 1, 0);
    ng;
    check("br_commit_clear0", 32'(clear_flag), 32'd0);
    nx;
    idle();
    ng;
    check("br_clear1", 32'(clear_flag), 32'd1);
    check("br_pc", pc_fact, 32'h100);
    check("br_rc", 32'(real_commit), 32'd1);
    check("br_no_commit", 32'(commit0_valid), 32'd0);
    nx;
    mtail = '0;
    ng;
    check("flush_empty", 32'(rob_empty), 32'd1);
    check("flush_tail", 32'(rob_tail), 32'd0);
    check("flush_head", 32'(rob_head), 32'd0);
    check("flush_clear", 32'(clear_flag), 32'd0);
    check("flush_pc", pc_fact, 32'd0);
    check("flush_cc", commit_count, 32'd1);
    nx;
    for (int i = 0; i < 5; i++) begin
      disp(5'(10 + i), `TypeRd, 1'b0, 32'd0, 32'd0, 1, 1);
      cyc;
    end
    idle();
    wb_set(0, 5'd4, 32'hA);
    wb_set(1, 5'd4, 32'hB);
    rs1_id = 5'd4;
    ng;
    check("dup_wb_rdy", 32'(rs1_ready), 32'd1);
    check("dup_wb_lookup", rs1_val, 32'hA);
    nx;
    idle();
    ng;
    check("dup_wb_stored_rdy", 32'(rs1_ready), 32'd1);
    check("dup_wb_stored", rs1_val, 32'hB);
    nx;
    wb_set(0, 5'd0, 32'h11);
    cyc;
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ng;
      check("stall_commit", 32'(commit0_valid), 32'd0);
      check("stall_cc", commit_count, 32'd1);
      check("stall_rc", 32'(real_commit), 32'd0);
      nx;
    end
    rdy_in = 1'b1;
    ng;
    check("resume_commit", 32'(commit0_valid), 32'd1);
    check("resume_id", 32'(commit0_id), 32'd0);
    nx;
    ng;
    check("resume_cc", commit_count, 32'd2);
    check("resume_rc", 32'(real_commit), 32'd1);
    nx;
    wb_set(0, 5'd1, 32'h21);
    wb_set(1, 5'd2, 32'h22);
    cyc;
    idle();
    wb_set(0, 5'd3, 32'h23);
    cyc;
    idle();
    drain;
    ng;
    check("pre_br2_cc", commit_count, 32'd6);
    nx;
    disp(5'd0, `TypeBr, 1'b1, 32'h104, 32'h0FD, 1, 0);
    cyc;
    idle();
    cyc;
    ng;
    check("br2_clear", 32'(clear_flag), 32'd1);
    check("br2_pc", pc_fact, 32'h104);
    check("br2_cc", commit_count, 32'd7);
    nx;
    do_reset;
    ng;
    chk_reset("rst_mid_flush");
    nx;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
